// File: rtl/mc_control_unit_pkg.sv
// Shared constants for the multicycle control unit: FSM states, opcodes,
// funct3 codes, ALU operation encodings and datapath mux selects.
package mc_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_R   = 2'd1,
    CLS_I   = 2'd2,
    CLS_BR  = 2'd3
  } alu_cls_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SRA = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_AND = 4'd7;
  localparam logic [3:0] ALU_BEQ = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;
  localparam logic [3:0] ALU_BLT = 4'd10;
  localparam logic [3:0] ALU_BGE = 4'd11;

  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_RS1 = 1'b1;
  localparam logic [1:0] SRC_B_RS2 = 2'b00;
  localparam logic [1:0] SRC_B_IMM = 2'b01;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  localparam logic       PCS_PC4   = 1'b0;
  localparam logic       PCS_ALU   = 1'b1;
  localparam logic       IORD_PC   = 1'b0;
  localparam logic       IORD_ALU  = 1'b1;

endpackage

// File: rtl/mc_control_unit_alu_control_unit.sv
// Funct-field to ALU opcode decode, selected by instruction class.
// o_br_ok flags a supported branch condition; others are treated as not taken.
module mc_control_unit_alu_control_unit
  import mc_control_unit_pkg::*;
(
  input  alu_cls_e   i_cls,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_op,
  output logic       o_br_ok
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_br_ok  = 1'b0;
    case (i_cls)
      CLS_R, CLS_I: begin
        case (i_funct3)
          F3_ADD: o_alu_op = (i_cls == CLS_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLL: o_alu_op = ALU_SLL;
          F3_XOR: o_alu_op = ALU_XOR;
          F3_SR:  o_alu_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
          F3_OR:  o_alu_op = ALU_OR;
          F3_AND: o_alu_op = ALU_AND;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      CLS_BR: begin
        o_br_ok = 1'b1;
        case (i_funct3)
          F3_BEQ: o_alu_op = ALU_BEQ;
          F3_BNE: o_alu_op = ALU_BNE;
          F3_BLT: o_alu_op = ALU_BLT;
          F3_BGE: o_alu_op = ALU_BGE;
          default: begin
            o_alu_op = ALU_ADD;
            o_br_ok  = 1'b0;
          end
        endcase
      end
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32 control FSM (IF/ID/EX/MEM/WB/HALT). Outputs are decoded
// combinationally from the state and current inputs, and forced low in reset.
module mc_control_unit
  import mc_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       bcond,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       pc_write,
  output logic       pc_source,
  output logic       halted
);

  state_e     r_state;
  state_e     w_next;
  alu_cls_e   w_cls;
  logic [3:0] w_alu_op;
  logic       w_br_ok;

  logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal, w_is_jalr, w_is_sys;
  logic w_to_ex;

  assign w_is_r    = (opcode == OPC_R);
  assign w_is_i    = (opcode == OPC_I);
  assign w_is_ld   = (opcode == OPC_LOAD);
  assign w_is_st   = (opcode == OPC_STORE);
  assign w_is_br   = (opcode == OPC_BRANCH);
  assign w_is_jal  = (opcode == OPC_JAL);
  assign w_is_jalr = (opcode == OPC_JALR);
  assign w_is_sys  = (opcode == OPC_SYSTEM);
  assign w_to_ex   = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br | w_is_jalr;

  // Class selection kept apart from the output decode to avoid a comb loop
  always_comb begin
    w_cls = CLS_ADD;
    if (r_state == S_EX) begin
      if (w_is_r)       w_cls = CLS_R;
      else if (w_is_i)  w_cls = CLS_I;
      else if (w_is_br) w_cls = CLS_BR;
    end
  end

  mc_control_unit_alu_control_unit u_alu_ctrl (
    .i_cls      (w_cls),
    .i_funct3   (funct3),
    .i_funct7_5 (funct7_5),
    .o_alu_op   (w_alu_op),
    .o_br_ok    (w_br_ok)
  );

  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = IORD_PC;
    ir_write  = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    pc_write  = 1'b0;
    pc_source = PCS_PC4;
    halted    = 1'b0;
    case (r_state)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          w_next   = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = SRC_B_IMM;
        alu_op    = w_alu_op;
        if (w_is_jal)      w_next = S_WB;
        else if (w_is_sys) w_next = S_HALT;
        else if (w_to_ex)  w_next = S_EX;
        else begin
          // Unknown opcode retires as a NOP
          pc_write = 1'b1;
          w_next   = S_IF;
        end
      end
      S_EX: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = (w_is_r || w_is_br) ? SRC_B_RS2 : SRC_B_IMM;
        alu_op    = w_alu_op;
        if (w_is_br) begin
          pc_write  = 1'b1;
          pc_source = (w_br_ok && bcond) ? PCS_ALU : PCS_PC4;
          w_next    = S_IF;
        end else if (w_is_ld || w_is_st) begin
          w_next = S_MEM;
        end else if (w_is_r || w_is_i || w_is_jalr) begin
          w_next = S_WB;
        end else begin
          w_next = S_IF;
        end
      end
      S_MEM: begin
        iord      = IORD_ALU;
        mem_read  = w_is_ld;
        mem_write = ~w_is_ld & w_is_st;
        if (mem_ready) begin
          if (w_is_ld) begin
            w_next = S_WB;
          end else begin
            pc_write = 1'b1;
            w_next   = S_IF;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (w_is_jal || w_is_jalr) begin
          wb_sel    = WB_PC4;
          pc_source = PCS_ALU;
        end else if (w_is_ld) begin
          wb_sel = WB_MDR;
        end
        w_next = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_IF;
    endcase
    if (!reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = IORD_PC;
      ir_write  = 1'b0;
      alu_src_a = SRC_A_PC;
      alu_src_b = SRC_B_RS2;
      alu_op    = ALU_ADD;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      pc_write  = 1'b0;
      pc_source = PCS_PC4;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed scoreboard bench for mc_control_unit: each cycle's expected output
// vector is queued with the stimulus and checked mid-cycle.
module tb_mc_control_unit;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LD   = 7'h03;
  localparam logic [6:0] OP_ST   = 7'h23;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  localparam logic [3:0] A_ADD = 4'd0,  A_SUB = 4'd1,  A_SLL = 4'd2, A_XOR = 4'd3;
  localparam logic [3:0] A_SRA = 4'd5,  A_AND = 4'd7;
  localparam logic [3:0] A_BNE = 4'd9,  A_BLT = 4'd10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       bcond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       pc_write, pc_source, halted;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .bcond(bcond), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write),
    .pc_source(pc_source), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [16:0] w_obs;
  assign w_obs = {mem_read, mem_write, iord, ir_write, alu_src_a, alu_src_b, alu_op,
                  reg_write, wb_sel, pc_write, pc_source, halted};

  typedef struct {
    logic [16:0] v;
    string       tag;
  } sb_t;
  sb_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [16:0] ex(input logic mr, input logic mw, input logic io,
      input logic irw, input logic sa, input logic [1:0] sb, input logic [3:0] aop,
      input logic rw, input logic [1:0] wb, input logic pw, input logic ps, input logic h);
    return {mr, mw, io, irw, sa, sb, aop, rw, wb, pw, ps, h};
  endfunction

  function automatic logic [16:0] x_if(input logic rdy);
    return ex(1, 0, 0, rdy, 0, 2'b00, A_ADD, 0, 2'b00, 0, 0, 0);
  endfunction

  function automatic logic [16:0] x_id();
    return ex(0, 0, 0, 0, 0, 2'b01, A_ADD, 0, 2'b00, 0, 0, 0);
  endfunction

  function automatic logic [16:0] x_wb(input logic [1:0] wb, input logic ps);
    return ex(0, 0, 0, 0, 0, 2'b00, A_ADD, 1, wb, 1, ps, 0);
  endfunction

  task automatic check();
    sb_t e;
    e = sbq.pop_front();
    n_tests++;
    assert (w_obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, w_obs, e.v);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic bc,
                      input logic [16:0] e, input string tag);
    sb_t s;
    reset = rst; mem_ready = rdy; bcond = bc;
    s.v = e; s.tag = tag;
    sbq.push_back(s);
    #3;
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    opcode = opc; funct3 = f3; funct7_5 = f7;
  endtask

  task automatic instr_ir(input logic [31:0] ir);
    opcode = ir[6:0]; funct3 = ir[14:12]; funct7_5 = ir[30];
  endtask

  task automatic run_alu(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [3:0] aop, input string tag);
    instr(opc, f3, f7);
    step(1, 1, 0, x_if(1), {tag, "_if"});
    step(1, 1, 0, x_id(), {tag, "_id"});
    step(1, 1, 0, ex(0, 0, 0, 0, 1, (opc == OP_R) ? 2'b00 : 2'b01, aop, 0, 2'b00, 0, 0, 0),
         {tag, "_ex"});
    step(1, 1, 0, x_wb(2'b00, 0), {tag, "_wb"});
  endtask

  task automatic run_br(input logic [2:0] f3, input logic bc, input logic [3:0] aop,
                        input logic ps, input string tag);
    instr(OP_BR, f3, 0);
    step(1, 1, bc, x_if(1), {tag, "_if"});
    step(1, 1, bc, x_id(), {tag, "_id"});
    step(1, 1, bc, ex(0, 0, 0, 0, 1, 2'b00, aop, 0, 2'b00, 1, ps, 0), {tag, "_ex"});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    step(0, 0, 0, 17'd0, "rst_a");
    step(0, 1, 0, 17'd0, "rst_b");

    instr_ir(32'h002081B3);
    step(1, 1, 0, x_if(1), "add_if");
    step(1, 1, 0, x_id(), "add_id");
    step(1, 1, 0, ex(0, 0, 0, 0, 1, 2'b00, A_ADD, 0, 2'b00, 0, 0, 0), "add_ex");
    step(1, 1, 0, x_wb(2'b00, 0), "add_wb");

    run_alu(OP_R, 3'b000, 1, A_SUB, "sub");
    run_alu(OP_R, 3'b101, 1, A_SRA, "sra");
    run_alu(OP_R, 3'b100, 0, A_XOR, "xor");
    run_alu(OP_I, 3'b000, 1, A_ADD, "addi");
    run_alu(OP_I, 3'b101, 1, A_SRA, "srai");
    run_alu(OP_I, 3'b001, 0, A_SLL, "slli");
    run_alu(OP_I, 3'b010, 0, A_ADD, "slti");
    run_alu(OP_I, 3'b111, 0, A_AND, "andi");

    instr(OP_LD, 3'b010, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, x_if(0), "lw_if_stall");
    step(1, 1, 0, x_if(1), "lw_if");
    step(1, 1, 0, x_id(), "lw_id");
    step(1, 1, 0, ex(0, 0, 0, 0, 1, 2'b01, A_ADD, 0, 2'b00, 0, 0, 0), "lw_ex");
    for (int i = 0; i < 2; i++)
      step(1, 0, 0, ex(1, 0, 1, 0, 0, 2'b00, A_ADD, 0, 2'b00, 0, 0, 0), "lw_mem_stall");
    step(1, 1, 0, ex(1, 0, 1, 0, 0, 2'b00, A_ADD, 0, 2'b00, 0, 0, 0), "lw_mem");
    step(1, 1, 0, x_wb(2'b01, 0), "lw_wb");

    instr(OP_ST, 3'b010, 0);
    step(1, 1, 0, x_if(1), "sw_if");
    step(1, 1, 0, x_id(), "sw_id");
    step(1, 1, 0, ex(0, 0, 0, 0, 1, 2'b01, A_ADD, 0, 2'b00, 0, 0, 0), "sw_ex");
    step(1, 1, 0, ex(0, 1, 1, 0, 0, 2'b00, A_ADD, 0, 2'b00, 1, 0, 0), "sw_mem");

    run_br(3'b001, 1, A_BNE, 1, "bne_t");
    run_br(3'b001, 0, A_BNE, 0, "bne_nt");
    run_br(3'b100, 1, A_BLT, 1, "blt_t");
    run_br(3'b010, 1, A_ADD, 0, "br_bad");

    instr(OP_JAL, 3'b000, 0);
    step(1, 1, 0, x_if(1), "jal_if");
    step(1, 1, 0, x_id(), "jal_id");
    step(1, 1, 0, x_wb(2'b10, 1), "jal_wb");

    instr(OP_JALR, 3'b000, 0);
    step(1, 1, 0, x_if(1), "jalr_if");
    step(1, 1, 0, x_id(), "jalr_id");
    step(1, 1, 0, ex(0, 0, 0, 0, 1, 2'b01, A_ADD, 0, 2'b00, 0, 0, 0), "jalr_ex");
    step(1, 1, 0, x_wb(2'b10, 1), "jalr_wb");

    instr(7'h00, 3'b000, 0);
    step(1, 1, 0, x_if(1), "nop_if");
    step(1, 1, 0, ex(0, 0, 0, 0, 0, 2'b01, A_ADD, 0, 2'b00, 1, 0, 0), "nop_id");

    instr(OP_ST, 3'b010, 0);
    step(1, 1, 0, x_if(1), "swr_if");
    step(1, 1, 0, x_id(), "swr_id");
    step(1, 1, 0, ex(0, 0, 0, 0, 1, 2'b01, A_ADD, 0, 2'b00, 0, 0, 0), "swr_ex");
    step(1, 0, 0, ex(0, 1, 1, 0, 0, 2'b00, A_ADD, 0, 2'b00, 0, 0, 0), "swr_mem_stall");
    step(0, 0, 0, 17'd0, "swr_reset");
    step(1, 0, 0, x_if(0), "swr_refetch");

    instr_ir(32'h00000073);
    step(1, 1, 0, x_if(1), "ecall_if");
    step(1, 1, 0, x_id(), "ecall_id");
    for (int i = 0; i < 20; i++)
      step(1, i[0], 0, ex(0, 0, 0, 0, 0, 2'b00, A_ADD, 0, 2'b00, 0, 0, 1), "halt");
    step(0, 1, 0, 17'd0, "halt_reset");
    step(1, 0, 0, x_if(0), "halt_refetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-low; sampled on rising clk only.
REQ-003 opcode  in  7  IR[6:0]; valid from ID onward.
REQ-004 funct3  in  3  IR[14:12].  funct7_5  in  1  IR[30].
REQ-005 bcond  in  1  ALU branch result (alu_bcond bit 0).
REQ-006 mem_ready  in  1  memory handshake; current mem_read/mem_write access completes this cycle.
REQ-007 mem_read, mem_write  out  1  memory request; held until mem_ready.
REQ-008 iord  out  1  address select: 0=PC, 1=ALUOut.
REQ-009 ir_write  out  1  latch instruction into IR.
REQ-010 alu_src_a  out  1  0=PC, 1=rs1.  alu_src_b  out  2  00=rs2, 01=imm, 10=const 4.
REQ-011 alu_op  out  4  ALU opcode, encodings from opcodes.v.
REQ-012 reg_write  out  1;  wb_sel  out  2  00=ALUOut, 01=MDR, 10=PC+4.
REQ-013 pc_write  out  1;  pc_source  out  1  0=PC+4, 1=ALUOut.
REQ-014 halted  out  1  set after ECALL retires.

Function
REQ-015 States SHALL be IF, ID, EX, MEM, WB, HALT; outputs SHALL be combinational from state, opcode, funct3, funct7_5, bcond, mem_ready; unlisted outputs are 0.
REQ-016 IF: mem_read=1, iord=0; on mem_ready=1 -> ir_write=1, next ID; otherwise stay in IF.
REQ-017 ID: alu_src_a=0, alu_src_b=01, alu_op=ADD (PC+imm into ALUOut); next: JAL->WB, ECALL->HALT, R/I-arith/LOAD/STORE/BRANCH/JALR->EX, unknown opcode -> pc_write=1, pc_source=0, next IF (NOP).
REQ-018 EX R-type: src_a=1, src_b=00, alu_op from funct3/funct7_5; next WB.
REQ-019 EX I-arith: src_a=1, src_b=01, alu_op from funct3 (funct7_5 used only for funct3=101); next WB.
REQ-020 EX LOAD/STORE/JALR: src_a=1, src_b=01, ADD; LOAD/STORE->MEM, JALR->WB.
REQ-021 EX BRANCH: src_a=1, src_b=00, alu_op 000 BEQ, 001 BNE, 100 BLT, 101 BGE; other funct3 forces not-taken; pc_write=1, pc_source=bcond; next IF.
REQ-022 MEM: iord=1; LOAD mem_read=1, STORE mem_write=1; stall until mem_ready; on mem_ready LOAD->WB, STORE -> pc_write=1, pc_source=0, next IF.
REQ-023 WB: reg_write=1, pc_write=1; R/I: wb_sel=00, pc_source=0; LOAD: wb_sel=01, pc_source=0; JAL/JALR: wb_sel=10, pc_source=1; next IF.
REQ-024 HALT: halted=1, pc_write=0, no memory request; stays until reset.
REQ-025 Funct mapping: 000 ADD (SUB when R-type and funct7_5=1), 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND; 010/011 -> ADD.
REQ-026 Exactly one pc_write pulse per retired instruction; none during stalls.
REQ-027 mem_read and mem_write SHALL never both be 1.

Reset
REQ-028 reset=0 at rising clk -> state IF, halted=0, irrespective of current state, including mid-stall in IF/MEM and HALT.
REQ-029 While reset=0, every output SHALL be 0 (memory request dropped, no pc_write, reg_write or ir_write).
REQ-030 First cycle with reset=1 SHALL issue the IF fetch (mem_read=1, iord=0).

Structure
REQ-031 Opcode, ALU-op and state-encoding constants SHALL live in shared opcodes.v; no literals in RTL.
REQ-032 Funct-to-alu_op decode SHALL be sub-module alu_control_unit (inputs: class R/I/branch/add, funct3, funct7_5).
REQ-033 One state register, 3 bits; illegal encodings SHALL return to IF.

Verification
REQ-034 ADD x3,x1,x2 (0x002081B3), mem_ready=1 always -> IF,ID,EX,WB; WB: reg_write=1, wb_sel=00, pc_write=1, pc_source=0; 4 cycles.
REQ-035 LW with mem_ready low 3 cycles in IF and 2 in MEM -> 10 cycles total, mem_read held stable, iord=1 in MEM, single pc_write.
REQ-036 BNE with bcond=1 -> EX alu_op=BNE, pc_source=1; same with bcond=0 -> pc_source=0; both 3 cycles.
REQ-037 JALR -> EX src_a=1, src_b=01, ADD; WB wb_sel=10, pc_source=1.
REQ-038 ECALL (0x00000073) -> HALT, halted=1 for 20 cycles, no requests; reset=0 one cycle -> IF, halted=0.
REQ-039 reset=0 during MEM stall of SW -> mem_write=0 that cycle, next state IF, no reg_write/pc_write.
